alu_share_ctrl: RTL and testbench

- Shares one 4-bit ALU_Mod datapath between two requesters.
- Performs round-robin arbitration, registers the operands, and holds them stable on the ALU inputs for a configurable settle time.
- Captures ALU_Out/CarryOut, flags divide-by-zero, and returns the result to the granted requester over a valid/ready response channel.
- Sits between requester logic and a single ALU_Mod instance. One operation is in flight at a time.

---
 rtl/alu_share_if.sv | 24 ++
 rtl/alu_share_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_share_if.sv
// Request/response bundle between the two requesters and alu_share_ctrl.
// Requester i owns bit i of each 2-bit vector and nibble i of each 8-bit field.
interface alu_share_if;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic [7:0] req_sel;
   logic [1:0] rsp_valid;
   logic [1:0] rsp_ready;
   logic [3:0] rsp_data;
   logic       rsp_carry;
   logic       rsp_err;

   modport master (
      output req_valid, req_a, req_b, req_sel, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, req_sel, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
   );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one 4-bit ALU_Mod between two requesters: one
// operation in flight, operands held for ALU_LAT cycles, result returned by valid/ready.
module alu_share_ctrl #(
   parameter int unsigned ALU_LAT = 1,
   parameter logic [3:0]  DIV_SEL = 4'd3
) (
   input  logic             clk,
   input  logic             rst,
   alu_share_if.slave       bus,
   output logic [3:0]       A,
   output logic [3:0]       B,
   output logic [3:0]       ALU_Sel,
   input  logic [3:0]       ALU_Out,
   input  logic             CarryOut,
   output logic             busy,
   output logic [7:0]       op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

   state_t     state, state_nxt;
   logic       last_grant;
   logic       grant;
   logic       accept;
   logic       rsp_take;
   logic       gnt_p0;
   logic [3:0] cnt_p0;
   logic [3:0] opa_p0, opb_p0, opsel_p0;
   logic [3:0] rsp_data_p1;
   logic       rsp_carry_p1;
   logic       rsp_err_p1;
   logic [5:0] cap_res;

   // Divide-by-zero overrides whatever the ALU produces: {err, carry, data}.
   function automatic logic [5:0] capture_result(input logic [3:0] sel,
                                                 input logic [3:0] b,
                                                 input logic [3:0] alu_out,
                                                 input logic       carry);
      if ((sel == DIV_SEL) && (b == 4'd0))
         return {1'b1, 1'b0, 4'd0};
      else
         return {1'b0, carry, alu_out};
   endfunction

   always_comb begin
      grant = 1'b0;
      unique case (bus.req_valid)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant;
         default: grant = 1'b0;
      endcase
   end

   assign accept   = (state == IDLE) && (bus.req_valid != 2'b00);
   assign rsp_take = (state == RESP) && bus.rsp_ready[gnt_p0];
   assign cap_res  = capture_result(opsel_p0, opb_p0, ALU_Out, CarryOut);

   always_comb begin
      state_nxt     = state;
      bus.req_ready = 2'b00;
      bus.rsp_valid = 2'b00;
      unique case (state)
         IDLE: begin
            if (accept) begin
               bus.req_ready = grant ? 2'b10 : 2'b01;
               state_nxt     = EXEC;
            end
         end
         EXEC: begin
            if (cnt_p0 == 4'd0)
               state_nxt = RESP;
         end
         RESP: begin
            bus.rsp_valid = gnt_p0 ? 2'b10 : 2'b01;
            if (rsp_take)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p0: operand latch and settle countdown
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         gnt_p0     <= 1'b0;
         cnt_p0     <= 4'd0;
         opa_p0     <= 4'd0;
         opb_p0     <= 4'd0;
         opsel_p0   <= 4'd0;
         op_count   <= 8'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            gnt_p0   <= grant;
            cnt_p0   <= CNT_INIT;
            opa_p0   <= grant ? bus.req_a[7:4]   : bus.req_a[3:0];
            opb_p0   <= grant ? bus.req_b[7:4]   : bus.req_b[3:0];
            opsel_p0 <= grant ? bus.req_sel[7:4] : bus.req_sel[3:0];
         end else if ((state == EXEC) && (cnt_p0 != 4'd0)) begin
            cnt_p0 <= cnt_p0 - 4'd1;
         end
         if (rsp_take) begin
            last_grant <= gnt_p0;
            op_count   <= op_count + 8'd1;
         end
      end
   end

   // Stage p1: result capture, held through RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_data_p1  <= 4'd0;
         rsp_carry_p1 <= 1'b0;
         rsp_err_p1   <= 1'b0;
      end else if ((state == EXEC) && (cnt_p0 == 4'd0)) begin
         rsp_err_p1   <= cap_res[5];
         rsp_carry_p1 <= cap_res[4];
         rsp_data_p1  <= cap_res[3:0];
      end
   end

   assign A             = opa_p0;
   assign B             = opb_p0;
   assign ALU_Sel       = opsel_p0;
   assign bus.rsp_data  = rsp_data_p1;
   assign bus.rsp_carry = rsp_carry_p1;
   assign bus.rsp_err   = rsp_err_p1;
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: one instance with ALU_LAT=1, one with ALU_LAT=3,
// each driving a small behavioural ALU_Mod.
module tb_alu_share_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_share_if if1 ();
   alu_share_if if3 ();

   logic [3:0] a1, b1, s1, o1, a3, b3, s3, o3;
   logic       c1, c3, busy1, busy3;
   logic [7:0] cnt1, cnt3;

   int errors = 0;
   int checks = 0;

   // Behavioural ALU: 0 add, 1 sub, 2 and, 3 div (divide by zero returns F with carry set).
   function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] sel);
      case (sel)
         4'd0:    return {1'b0, a} + {1'b0, b};
         4'd1:    return {1'b0, a} - {1'b0, b};
         4'd2:    return {1'b0, a & b};
         4'd3:    return (b == 4'd0) ? 5'h1F : {1'b0, a / b};
         default: return 5'd0;
      endcase
   endfunction

   assign {c1, o1} = alu_model(a1, b1, s1);
   assign {c3, o3} = alu_model(a3, b3, s3);

   alu_share_ctrl #(.ALU_LAT(1), .DIV_SEL(4'd3)) dut1 (
      .clk(clk), .rst(rst), .bus(if1), .A(a1), .B(b1), .ALU_Sel(s1),
      .ALU_Out(o1), .CarryOut(c1), .busy(busy1), .op_count(cnt1));

   alu_share_ctrl #(.ALU_LAT(3), .DIV_SEL(4'd3)) dut3 (
      .clk(clk), .rst(rst), .bus(if3), .A(a3), .B(b3), .ALU_Sel(s3),
      .ALU_Out(o3), .CarryOut(c3), .busy(busy3), .op_count(cnt3));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge; drive there, sample #1 later.
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] exp_data [2];
      if1.req_valid = 2'b00; if1.req_a = 8'h00; if1.req_b = 8'h00; if1.req_sel = 8'h00;
      if1.rsp_ready = 2'b00;
      if3.req_valid = 2'b00; if3.req_a = 8'h00; if3.req_b = 8'h00; if3.req_sel = 8'h00;
      if3.rsp_ready = 2'b00;

      // Reset state
      step(); step(); #1;
      chk("rst_busy", {7'd0, busy1}, 8'd0);
      chk("rst_opcnt", cnt1, 8'd0);
      chk("rst_rspv", {6'd0, if1.rsp_valid}, 8'd0);
      chk("rst_rdy", {6'd0, if1.req_ready}, 8'd0);
      chk("rst_A", {4'd0, a1}, 8'd0);
      chk("rst_data", {4'd0, if1.rsp_data}, 8'd0);
      rst = 1'b0;

      // Single add: 9 + 8 = 1 carry 1
      step();
      if1.req_valid = 2'b01; if1.req_a = 8'h09; if1.req_b = 8'h08; if1.req_sel = 8'h00;
      #1 chk("add_rdy", {6'd0, if1.req_ready}, 8'h01);
      step(); if1.req_valid = 2'b00;
      #1 chk("add_exec_A", {4'd0, a1}, 8'h09);
      chk("add_exec_rspv", {6'd0, if1.rsp_valid}, 8'h00);
      step(); #1;
      chk("add_rspv", {6'd0, if1.rsp_valid}, 8'h01);
      chk("add_data", {4'd0, if1.rsp_data}, 8'h01);
      chk("add_carry", {7'd0, if1.rsp_carry}, 8'h01);
      chk("add_err", {7'd0, if1.rsp_err}, 8'h00);
      if1.rsp_ready = 2'b01;
      step(); if1.rsp_ready = 2'b00;
      #1 chk("add_opcnt", cnt1, 8'd1);
      chk("add_idle", {7'd0, busy1}, 8'd0);

      // Reset pulse, then reset in the middle of a requester-1 operation
      rst = 1'b1;
      step(); rst = 1'b0;
      if1.req_valid = 2'b10; if1.req_a = 8'h40; if1.req_b = 8'h40; if1.req_sel = 8'h00;
      #1 chk("mid_rdy", {6'd0, if1.req_ready}, 8'h02);
      step(); if1.req_valid = 2'b00;
      #1 chk("mid_busy", {7'd0, busy1}, 8'd1);
      rst = 1'b1;
      step(); rst = 1'b0;
      #1 chk("mid_rst_busy", {7'd0, busy1}, 8'd0);
      chk("mid_rst_rspv", {6'd0, if1.rsp_valid}, 8'h00);
      chk("mid_rst_opcnt", cnt1, 8'd0);

      // Contention: req0 2+3=5, req1 7-5=2; grants alternate starting at 0
      if1.req_valid = 2'b11; if1.req_a = 8'h72; if1.req_b = 8'h53; if1.req_sel = 8'h10;
      if1.rsp_ready = 2'b11;
      exp_data[0] = 4'd5; exp_data[1] = 4'd2;
      for (int i = 0; i < 4; i++) begin
         #1 chk($sformatf("cont_rdy%0d", i), {6'd0, if1.req_ready}, (i % 2 == 0) ? 8'h01 : 8'h02);
         step(); #1;
         chk($sformatf("cont_exec_rdy%0d", i), {6'd0, if1.req_ready}, 8'h00);
         step(); #1;
         chk($sformatf("cont_rspv%0d", i), {6'd0, if1.rsp_valid}, (i % 2 == 0) ? 8'h01 : 8'h02);
         chk($sformatf("cont_data%0d", i), {4'd0, if1.rsp_data}, {4'd0, exp_data[i % 2]});
         step();
      end
      if1.req_valid = 2'b00; if1.rsp_ready = 2'b00;
      #1 chk("cont_opcnt", cnt1, 8'd4);

      // Divide by zero on requester 1, then a legal divide 8/2=4
      step();
      if1.req_valid = 2'b10; if1.req_a = 8'h70; if1.req_b = 8'h00; if1.req_sel = 8'h30;
      #1 chk("dz_rdy", {6'd0, if1.req_ready}, 8'h02);
      step(); if1.req_valid = 2'b00;
      step(); if1.rsp_ready = 2'b01;
      #1 chk("dz_rspv", {6'd0, if1.rsp_valid}, 8'h02);
      chk("dz_err", {7'd0, if1.rsp_err}, 8'h01);
      chk("dz_data", {4'd0, if1.rsp_data}, 8'h00);
      chk("dz_carry", {7'd0, if1.rsp_carry}, 8'h00);
      step();
      #1 chk("dz_wrong_ready_ignored", {6'd0, if1.rsp_valid}, 8'h02);
      if1.rsp_ready = 2'b10;
      step(); if1.rsp_ready = 2'b00;
      if1.req_valid = 2'b10; if1.req_a = 8'h80; if1.req_b = 8'h20; if1.req_sel = 8'h30;
      #1 chk("div_rdy", {6'd0, if1.req_ready}, 8'h02);
      step(); if1.req_valid = 2'b00;
      step(); #1;
      chk("div_err", {7'd0, if1.rsp_err}, 8'h00);
      chk("div_data", {4'd0, if1.rsp_data}, 8'h04);
      if1.rsp_ready = 2'b10;
      step(); if1.rsp_ready = 2'b00;
      #1 chk("div_opcnt", cnt1, 8'd6);

      // Backpressure: req1 5+6=B stalls in RESP while req0 (3+4=7) waits
      if1.req_valid = 2'b10; if1.req_a = 8'h53; if1.req_b = 8'h64; if1.req_sel = 8'h00;
      step(); if1.req_valid = 2'b01;
      step();
      for (int i = 0; i < 5; i++) begin
         #1 chk($sformatf("bp_rspv%0d", i), {6'd0, if1.rsp_valid}, 8'h02);
         chk($sformatf("bp_data%0d", i), {4'd0, if1.rsp_data}, 8'h0B);
         chk($sformatf("bp_busy%0d", i), {7'd0, busy1}, 8'h01);
         chk($sformatf("bp_rdy%0d", i), {6'd0, if1.req_ready}, 8'h00);
         step();
      end
      if1.rsp_ready = 2'b10;
      step(); if1.rsp_ready = 2'b00;
      #1 chk("bp_grant0", {6'd0, if1.req_ready}, 8'h01);
      step(); if1.req_valid = 2'b00;
      step(); #1;
      chk("bp_data_req0", {4'd0, if1.rsp_data}, 8'h07);
      if1.rsp_ready = 2'b01;
      step(); if1.rsp_ready = 2'b00;
      #1 chk("bp_opcnt", cnt1, 8'd8);

      // Latency with ALU_LAT=3: 6+5=B, inputs changed after accept
      if3.req_valid = 2'b01; if3.req_a = 8'h06; if3.req_b = 8'h05; if3.req_sel = 8'h00;
      #1 chk("lat_rdy", {6'd0, if3.req_ready}, 8'h01);
      step();
      if3.req_valid = 2'b00; if3.req_a = 8'h01; if3.req_b = 8'h01; if3.req_sel = 8'h01;
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("lat_A%0d", i), {a3, b3}, 8'h65);
         chk($sformatf("lat_sel%0d", i), {4'd0, s3}, 8'h00);
         chk($sformatf("lat_rspv%0d", i), {6'd0, if3.rsp_valid}, 8'h00);
         step();
      end
      #1 chk("lat_rspv", {6'd0, if3.rsp_valid}, 8'h01);
      chk("lat_data", {4'd0, if3.rsp_data}, 8'h0B);
      if3.rsp_ready = 2'b01;
      step(); if3.rsp_ready = 2'b00;
      #1 chk("lat_opcnt", cnt3, 8'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
